// File: rtl/iitk_mini_mips_cpu.sv
// Single-cycle MIPS-subset core with a host-loadable instruction memory.
// Load mode (init_mode=1) halts the core; run mode executes one instruction per clock.
module iitk_mini_mips_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_mode,
  input  logic        write_enable,
  input  logic [11:0] init_address,
  input  logic [31:0] init_instruction,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic [31:0] debug_result
);
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic [31:0] imem [0:4095];
  logic [31:0] dmem [0:1023];
  logic [31:0] regs [0:31];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, wb_reg;
  logic [31:0] sext_imm, zext_imm, rs_val, rt_val, pc_plus4;
  logic [31:0] alu_result, wb_data, next_pc;
  logic        wb_en, mem_write, is_load, is_link;

  assign instruction_out = imem[pc_out[13:2]];
  assign opcode   = instruction_out[31:26];
  assign rs       = instruction_out[25:21];
  assign rt       = instruction_out[20:16];
  assign rd       = instruction_out[15:11];
  assign shamt    = instruction_out[10:6];
  assign funct    = instruction_out[5:0];
  assign sext_imm = {{16{instruction_out[15]}}, instruction_out[15:0]};
  assign zext_imm = {16'h0000, instruction_out[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : regs[rt];
  assign pc_plus4 = pc_out + 32'd4;
  assign debug_result = alu_result;

  // Decode, ALU and next-PC selection; anything unrecognised falls through as a NOP.
  always_comb begin
    alu_result = 32'd0;
    wb_en      = 1'b0;
    wb_reg     = rt;
    mem_write  = 1'b0;
    is_load    = 1'b0;
    is_link    = 1'b0;
    next_pc    = pc_plus4;
    case (opcode)
      6'h00: begin
        wb_reg = rd;
        wb_en  = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_result = rs_val + rt_val;
          6'h22, 6'h23: alu_result = rs_val - rt_val;
          6'h24: alu_result = rs_val & rt_val;
          6'h25: alu_result = rs_val | rt_val;
          6'h26: alu_result = rs_val ^ rt_val;
          6'h27: alu_result = ~(rs_val | rt_val);
          6'h2A: alu_result = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: alu_result = {31'd0, rs_val < rt_val};
          6'h00: alu_result = rt_val << shamt;
          6'h02: alu_result = rt_val >> shamt;
          6'h03: alu_result = $signed(rt_val) >>> shamt;
          6'h08: begin
            wb_en   = 1'b0;
            next_pc = rs_val;
          end
          default: wb_en = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin alu_result = rs_val + sext_imm; wb_en = 1'b1; end
      6'h0A: begin alu_result = {31'd0, $signed(rs_val) < $signed(sext_imm)}; wb_en = 1'b1; end
      6'h0C: begin alu_result = rs_val & zext_imm; wb_en = 1'b1; end
      6'h0D: begin alu_result = rs_val | zext_imm; wb_en = 1'b1; end
      6'h0E: begin alu_result = rs_val ^ zext_imm; wb_en = 1'b1; end
      6'h0F: begin alu_result = {instruction_out[15:0], 16'h0000}; wb_en = 1'b1; end
      6'h23: begin alu_result = rs_val + sext_imm; wb_en = 1'b1; is_load = 1'b1; end
      6'h2B: begin alu_result = rs_val + sext_imm; mem_write = 1'b1; end
      6'h04, 6'h05: begin
        alu_result = rs_val - rt_val;
        if ((rs_val == rt_val) == (opcode == 6'h04))
          next_pc = pc_plus4 + {sext_imm[29:0], 2'b00};
      end
      6'h02: next_pc = {pc_plus4[31:28], instruction_out[25:0], 2'b00};
      6'h03: begin
        next_pc = {pc_plus4[31:28], instruction_out[25:0], 2'b00};
        wb_reg  = 5'd31;
        wb_en   = 1'b1;
        is_link = 1'b1;
      end
      default: ;
    endcase
    if (is_load)      wb_data = dmem[alu_result[11:2]];
    else if (is_link) wb_data = pc_plus4;
    else              wb_data = alu_result;
  end

  always_ff @(posedge clk) begin
    if (init_mode && write_enable)
      imem[init_address] <= init_instruction;
  end

  always_ff @(posedge clk) begin
    if (reset && !init_mode && mem_write)
      dmem[alu_result[11:2]] <= rt_val;
  end

  // Reset clears PC and registers only; memories keep their contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (!init_mode) begin
      pc_out <= next_pc;
      if (wb_en && wb_reg != 5'd0)
        regs[wb_reg] <= wb_data;
    end
  end
endmodule

// File: tb/tb_iitk_mini_mips_cpu.sv
// Self-checking bench for iitk_mini_mips_cpu: directed programs plus random programs
// compared cycle by cycle against an instruction-level model of the ISA.
module tb_iitk_mini_mips_cpu;
  logic        clk = 1'b0;
  logic        reset, init_mode, write_enable;
  logic [11:0] init_address;
  logic [31:0] init_instruction, pc_out, instruction_out, debug_result;

  int checks = 0;
  int errors = 0;
  int base;

  logic [31:0] m_imem [0:4095];
  logic [31:0] m_dmem [0:1023];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc;

  iitk_mini_mips_cpu dut (
    .clk(clk), .reset(reset), .init_mode(init_mode), .write_enable(write_enable),
    .init_address(init_address), .init_instruction(init_instruction),
    .pc_out(pc_out), .instruction_out(instruction_out), .debug_result(debug_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int op, int idx);
    return {6'(op), 26'(32'h0010_0000 + idx)};
  endfunction

  function automatic logic [5:0] pick_funct(int k);
    case (k)
      0: return 6'h20;  1: return 6'h21;  2: return 6'h22;  3: return 6'h23;
      4: return 6'h24;  5: return 6'h25;  6: return 6'h26;  7: return 6'h27;
      8: return 6'h2A;  9: return 6'h2B; 10: return 6'h00; 11: return 6'h02;
      12: return 6'h03;
      default: return 6'h01;
    endcase
  endfunction

  function automatic logic [5:0] pick_op(int k);
    case (k)
      0: return 6'h08;  1: return 6'h09;  2: return 6'h0A;  3: return 6'h0C;
      4: return 6'h0D;  5: return 6'h0E;  6: return 6'h0F;  7: return 6'h23;
      8: return 6'h2B;  9: return 6'h04; 10: return 6'h05; 11: return 6'h02;
      12: return 6'h03;
      default: return 6'h0B;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    int sel = $urandom_range(0, 28);
    int rs  = $urandom_range(0, 7);
    int rt  = $urandom_range(0, 7);
    int rd  = $urandom_range(0, 7);
    logic [5:0] op;
    if (sel < 14) return enc_r(rs, rt, rd, $urandom_range(0, 31), pick_funct(sel));
    if (sel == 14) return enc_r(31, 0, 0, 0, 'h08);
    op = pick_op(sel - 15);
    if (op == 6'h04 || op == 6'h05) return enc_i(op, rs, rt, $urandom_range(0, 8) - 3);
    if (op == 6'h02 || op == 6'h03) return enc_j(op, $urandom_range(0, 63));
    return enc_i(op, rs, rt, $urandom);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 32'h0040_0000;
  endtask

  // Executes the instruction at m_pc on the model state and returns its ALU value.
  task automatic model_step(output logic [31:0] dbg);
    logic [31:0] ins, a, b, se, ze, res, npc, wdata;
    int dest;
    bit wr, load, link;
    ins = m_imem[m_pc[13:2]];
    a = m_regs[ins[25:21]];
    b = m_regs[ins[20:16]];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0000, ins[15:0]};
    res = 0; npc = m_pc + 4; wr = 0; load = 0; link = 0; wdata = 0;
    dest = int'(ins[20:16]);
    case (ins[31:26])
      6'h00: begin
        dest = int'(ins[15:11]);
        wr = 1;
        case (ins[5:0])
          6'h20, 6'h21: res = a + b;
          6'h22, 6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
          6'h2B: res = (a < b) ? 1 : 0;
          6'h00: res = b << ins[10:6];
          6'h02: res = b >> ins[10:6];
          6'h03: res = $signed(b) >>> ins[10:6];
          6'h08: begin wr = 0; npc = a; end
          default: wr = 0;
        endcase
      end
      6'h08, 6'h09: begin res = a + se; wr = 1; end
      6'h0A: begin res = ($signed(a) < $signed(se)) ? 1 : 0; wr = 1; end
      6'h0C: begin res = a & ze; wr = 1; end
      6'h0D: begin res = a | ze; wr = 1; end
      6'h0E: begin res = a ^ ze; wr = 1; end
      6'h0F: begin res = ze << 16; wr = 1; end
      6'h23: begin res = a + se; wr = 1; load = 1; wdata = m_dmem[res[11:2]]; end
      6'h2B: begin res = a + se; m_dmem[res[11:2]] = b; end
      6'h04: begin res = a - b; if (a == b) npc = m_pc + 4 + se * 4; end
      6'h05: begin res = a - b; if (a != b) npc = m_pc + 4 + se * 4; end
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin
        npc = {npc[31:28], ins[25:0], 2'b00};
        wr = 1; link = 1; dest = 31; wdata = m_pc + 4;
      end
      default: ;
    endcase
    if (!load && !link) wdata = res;
    if (wr && dest != 0) m_regs[dest] = wdata;
    m_pc = npc;
    dbg = res;
  endtask

  task automatic step_check(input string tag);
    logic [31:0] exp_dbg;
    check_output({tag, " pc"}, pc_out, m_pc);
    check_output({tag, " instr"}, instruction_out, m_imem[m_pc[13:2]]);
    model_step(exp_dbg);
    check_output({tag, " dbg"}, debug_result, exp_dbg);
    @(posedge clk); #1;
  endtask

  task automatic load_word(input int idx, input logic [31:0] w);
    init_mode = 1'b1;
    write_enable = 1'b1;
    init_address = 12'(idx);
    init_instruction = w;
    @(posedge clk); #1;
    write_enable = 1'b0;
    m_imem[12'(idx)] = w;
  endtask

  task automatic apply_stimulus_restart();
    init_mode = 1'b1;
    reset = 1'b0;
    #1;
    check_output("reset pc", pc_out, 32'h0040_0000);
    model_reset();
    reset = 1'b1;
    init_mode = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init_mode = 1'b1; write_enable = 1'b0;
    init_address = '0; init_instruction = '0;
    for (int i = 0; i < 1024; i++) m_dmem[i] = 32'd0;
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_output("por pc", pc_out, 32'h0040_0000);
    reset = 1'b1;
    for (int i = 0; i < 4096; i++) load_word(i, 32'd0);

    // Basic arithmetic chain
    load_word(0, enc_i('h08, 0, 8, 5));
    load_word(1, enc_i('h08, 0, 9, 10));
    load_word(2, enc_r(8, 9, 10, 0, 'h20));
    apply_stimulus_restart();
    check_output("t1 dbg0", debug_result, 32'd5);  step_check("t1a");
    check_output("t1 dbg1", debug_result, 32'hA);  step_check("t1b");
    check_output("t1 dbg2", debug_result, 32'hF);  step_check("t1c");
    check_output("t1 pc end", pc_out, 32'h0040_000C);

    // Load mode holds the core
    apply_stimulus_restart();
    init_mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("hold pc", pc_out, 32'h0040_0000);
    init_mode = 1'b0;
    step_check("hold go");
    check_output("hold pc4", pc_out, 32'h0040_0004);

    // Store/load round trip and signed compare
    load_word(0, enc_i('h08, 0, 8, 'hFFFF));
    load_word(1, enc_i('h2B, 0, 8, 8));
    load_word(2, enc_i('h23, 0, 9, 8));
    load_word(3, enc_r(9, 0, 10, 0, 'h2A));
    load_word(4, enc_r(9, 0, 0, 0, 'h21));
    load_word(5, enc_r(10, 0, 0, 0, 'h21));
    apply_stimulus_restart();
    for (int i = 0; i < 3; i++) step_check($sformatf("mem%0d", i));
    check_output("slt dbg", debug_result, 32'd1);         step_check("mem3");
    check_output("t1 value", debug_result, 32'hFFFF_FFFF); step_check("mem4");
    check_output("t2 value", debug_result, 32'd1);         step_check("mem5");

    // Taken branch skips one word
    load_word(0, enc_i('h08, 0, 8, 1));
    load_word(1, enc_i('h04, 8, 8, 1));
    load_word(2, enc_i('h08, 0, 9, 99));
    load_word(3, enc_i('h08, 0, 9, 5));
    apply_stimulus_restart();
    step_check("br0");
    check_output("br pc before", pc_out, 32'h0040_0004);
    step_check("br1");
    check_output("br pc after", pc_out, 32'h0040_000C);
    step_check("br3");

    // Writes to $0 are discarded
    load_word(0, enc_i('h08, 0, 0, 7));
    load_word(1, enc_r(0, 0, 8, 0, 'h20));
    apply_stimulus_restart();
    step_check("z0");
    check_output("zero reg", debug_result, 32'd0);
    step_check("z1");

    // Reset mid-run clears registers, keeps IMEM
    load_word(0, enc_i('h08, 0, 8, 5));
    load_word(1, enc_i('h08, 0, 9, 10));
    load_word(2, enc_r(8, 9, 10, 0, 'h20));
    apply_stimulus_restart();
    step_check("mr0");
    step_check("mr1");
    check_output("mr pc8", pc_out, 32'h0040_0008);
    reset = 1'b0;
    #1;
    check_output("mr reset pc", pc_out, 32'h0040_0000);
    check_output("mr imem kept", instruction_out, 32'h2008_0005);
    model_reset();
    init_mode = 1'b1;
    reset = 1'b1;
    load_word(0, enc_r(8, 0, 0, 0, 'h21));
    check_output("mr live load", instruction_out, 32'h0100_0021);
    check_output("mr reg cleared", debug_result, 32'd0);
    init_mode = 1'b0;
    step_check("mr2");
    check_output("mr next instr", instruction_out, 32'h2009_000A);

    // Fetch wraps from the last IMEM word back to index 0
    load_word(4095, enc_i('h08, 0, 8, 3));
    load_word(0, enc_j('h02, 4095));
    apply_stimulus_restart();
    step_check("wr0");
    check_output("wrap pc top", pc_out, 32'h0040_3FFC);
    step_check("wr1");
    check_output("wrap pc", pc_out, 32'h0040_4000);
    check_output("wrap instr", instruction_out, 32'h0810_0FFF);
    step_check("wr2");

    // Random programs, then dump every register through debug_result
    for (int trial = 0; trial < 3; trial++) begin
      for (int i = 0; i < 48; i++) load_word(i, rand_instr());
      apply_stimulus_restart();
      for (int s = 0; s < 60; s++) step_check($sformatf("rnd%0d.%0d", trial, s));
      base = int'(m_pc[13:2]);
      for (int r = 1; r < 32; r++) load_word((base + r - 1) % 4096, enc_r(r, 0, 0, 0, 'h21));
      init_mode = 1'b0;
      for (int r = 1; r < 32; r++) step_check($sformatf("dump%0d.r%0d", trial, r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iitk_mini_mips_cpu.md
# iitk_mini_mips_cpu

Single-cycle 32-bit MIPS-subset processor with a loadable instruction memory. It is the top-level compute block of the mini-MIPS design. A host first writes a program word-by-word through the init port, then releases the core to execute from 0x00400000. Each cycle it exposes PC, the fetched instruction and the ALU result for debug/monitoring.

## Interface
- No parameters; fixed geometry: IMEM 4096×32, DMEM 1024×32, 32×32 register file.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low (0 = in reset); clears PC and register file.
- init_mode  input  1  1 = load mode, core halted; 0 = run mode.
- write_enable  input  1  IMEM write strobe, honoured only when init_mode=1.
- init_address  input  12  IMEM word index for load writes.
- init_instruction  input  32  word written to IMEM[init_address].
- pc_out  output  32  current PC register.
- instruction_out  output  32  IMEM word addressed by PC (combinational).
- debug_result  output  32  ALU result of instruction_out (combinational).

## Operation
- Load: on posedge, if init_mode=1 and write_enable=1, IMEM[init_address] <= init_instruction. Independent of reset; IMEM is never cleared by reset. IMEM/DMEM power up all-zero (0x00000000 = sll $0,$0,0 = NOP).
- Fetch: IMEM index = pc_out[13:2] (PC − 0x00400000 word offset, wraps modulo 4096 words).
- Register file: $0 reads 0, writes to $0 discarded; two combinational reads, one write per cycle.
- R-type (op 0x00), funct: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A (signed), sltu 0x2B, sll 0x00, srl 0x02, sra 0x03 (shamt), jr 0x08. Write rd.
- I-type: addi 0x08 / addiu 0x09 (sign-ext), slti 0x0A, andi 0x0C / ori 0x0D / xori 0x0E (zero-ext), lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05. Write rt.
- J-type: j 0x02, jal 0x03 (writes PC+4 to $31).
- Arithmetic is 32-bit modulo; overflow never traps (add≡addu, sub≡subu, addi≡addiu).
- lw/sw: address = rs + sext(imm); DMEM word index = addr[11:2]; low 2 bits ignored.
- Branch target = PC+4 + (sext(imm)<<2); jump target = {PC+4[31:28], target26, 2'b00}.
- Unsupported opcode/funct: NOP (no register/memory write), PC+4.
- debug_result: ALU output (address for lw/sw, rs−rt for beq/bne, 0 for j/jal/jr/NOP).

## Timing
- Reset asserted (reset=0): immediately pc_out=0x00400000, all registers 0; instruction_out/debug_result follow combinationally; DMEM retained.
- Core advances only when reset=1 and init_mode=0; otherwise PC, registers, DMEM hold.
- Single cycle: instruction at PC completes on the next posedge; register/DMEM write and PC update in that same edge. Taken branch/jump has no delay slot.
- Reset asserted mid-run aborts in-flight instruction (no write); resumes from 0x00400000 after release.
- Load-mode writes to the currently addressed word change instruction_out same cycle after the edge.
- Result of instruction N available to N+1 (register write at edge, read combinational afterwards).

## Test plan
- Load addi $t0,$0,5 / addi $t1,$0,10 / add $t2,$t0,$t1 at indices 0-2, release -> debug_result 5, 0xA, 0xF at PC 0x00400000/04/08; PC reaches 0x0040000C.
- Hold init_mode=1 with reset=1 -> pc_out stays 0x00400000; switching to 0 starts fetch.
- addi $t0,$0,-1; sw $t0,8($0); lw $t1,8($0); slt $t2,$t1,$0 -> $t1=0xFFFFFFFF, $t2=1.
- addi $t0,$0,1; beq $t0,$t0,+1 skips next word -> PC 0x00400004 → 0x0040000C.
- addi $0,$0,7 then add $t0,$0,$0 -> debug_result 0 (writes to $0 discarded).
- Assert reset=0 at PC 0x00400008 between edges -> pc_out=0x00400000 immediately, registers 0, IMEM intact.
